display_mux_receiver: RTL

Receiving end of the multiplexed 4-digit 7-segment bus that the display driver produces (digits, segments).
- Samples the bus on the 50 MHz system clock and waits for each digit dwell to settle.
- Demultiplexes the bus into four stable segment registers and publishes them atomically once per complete scan frame.
- Decodes the dozens and units digits back to binary.
- Used as an on-chip display monitor and self-check path beside the irrigation top level.

---
 rtl/display_pkg.sv | 56 +++++
 rtl/display_mux_receiver_if.sv | 8 +
 rtl/seg_settle_filter.sv | 87 ++++++++
 rtl/display_mux_receiver.sv | 119 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit 7-segment display bus: digit slots,
// segment bit positions, active-high digit encodings and their decoder.
package display_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_UNITS  = 2'd0;
  localparam dig_idx_t DIG_DOZENS = 2'd1;
  localparam dig_idx_t DIG_EXTRA  = 2'd2;
  localparam dig_idx_t DIG_STATES = 2'd3;

  // Bit positions inside a segment byte {dp,g,f,e,d,c,b,a}.
  typedef enum int unsigned {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  // Active-high encodings, dp clear.
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  // Returns {legal, value}; an unknown pattern yields {0, 0}. dp is not passed in.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'd0;
    case ({1'b0, pat})
      SEG_0:   r = {1'b1, 4'd0};
      SEG_1:   r = {1'b1, 4'd1};
      SEG_2:   r = {1'b1, 4'd2};
      SEG_3:   r = {1'b1, 4'd3};
      SEG_4:   r = {1'b1, 4'd4};
      SEG_5:   r = {1'b1, 4'd5};
      SEG_6:   r = {1'b1, 4'd6};
      SEG_7:   r = {1'b1, 4'd7};
      SEG_8:   r = {1'b1, 4'd8};
      SEG_9:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/display_mux_receiver_if.sv
// Raw multiplexed display bus as seen on the pins (polarity as driven).
interface display_mux_receiver_if;
  logic [3:0] digits;
  logic [7:0] segments;

  modport master (output digits, output segments);
  modport slave  (input  digits, input  segments);
endinterface

// File: rtl/seg_settle_filter.sv
// Synchronises the raw bus, normalises polarity and waits for each digit
// dwell to hold steady before issuing a single capture (or multi-hot) strobe.
module seg_settle_filter
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 16,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic [3:0] digits_i,
  input  logic [7:0] segments_i,
  output logic     cap_stb_o,
  output dig_idx_t cap_idx_o,
  output logic [7:0] cap_seg_o,
  output logic     multi_stb_o
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [3:0] dig_s1_q, dig_s2_q, dig_prev_q;
  logic [7:0] seg_s1_q, seg_s2_q, seg_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       captured_q, captured_d;
  logic [3:0] dig_n;
  logic [7:0] seg_n;
  logic       same, fire;

  assign dig_n = DIGIT_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q;
  assign seg_n = SEG_ACTIVE_LOW   ? ~seg_s2_q : seg_s2_q;
  assign same  = (dig_n == dig_prev_q) && (seg_n == seg_prev_q);

  // The previous sample has been stable long enough; it is the one captured.
  assign fire        = (cnt_q == SETTLE) && !captured_q;
  assign cap_stb_o   = fire && $onehot(dig_prev_q);
  assign multi_stb_o = fire && !$onehot0(dig_prev_q);
  assign cap_seg_o   = seg_prev_q;

  // One-hot digit vector to slot index.
  always_comb begin
    cap_idx_o = DIG_UNITS;
    case (dig_prev_q)
      4'b0010: cap_idx_o = DIG_DOZENS;
      4'b0100: cap_idx_o = DIG_EXTRA;
      4'b1000: cap_idx_o = DIG_STATES;
      default: cap_idx_o = DIG_UNITS;
    endcase
  end

  // Settle counter and once-per-dwell flag; a new sample restarts both.
  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    if (fire && (dig_prev_q != 4'b0000)) captured_d = 1'b1;
    if (!same) begin
      cnt_d      = 8'd0;
      captured_d = 1'b0;
    end else if (cnt_q != SETTLE) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Synchroniser, previous-sample store and settle state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      dig_prev_q <= '0;
      seg_prev_q <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      dig_s1_q   <= digits_i;
      dig_s2_q   <= dig_s1_q;
      seg_s1_q   <= segments_i;
      seg_s2_q   <= seg_s1_q;
      dig_prev_q <= dig_n;
      seg_prev_q <= seg_n;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
    end
  end

endmodule

// File: rtl/display_mux_receiver.sv
// Display bus monitor: collects one capture per digit slot into shadows and
// publishes all four digits plus the decoded value once a frame is complete.
module display_mux_receiver
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES   = 1048576,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic clock_50MHz,
  input  logic reset,
  display_mux_receiver_if.slave disp_bus,
  output logic [7:0] seg_states,
  output logic [7:0] seg_extra,
  output logic [7:0] seg_dozens,
  output logic [7:0] seg_units,
  output logic [1:0] dozens,
  output logic [3:0] units,
  output logic       value_ok,
  output logic       frame_valid,
  output logic       stale,
  output logic       bus_error
);

  localparam logic [20:0] TMO = 21'(TIMEOUT_CYCLES);

  logic       cap_stb, multi_stb;
  dig_idx_t   cap_idx;
  logic [7:0] cap_seg;

  logic [7:0]  shadow_q [4];
  logic [3:0]  seen_q, seen_d, cap_mask;
  logic [20:0] tmo_q, tmo_d;
  logic        complete;
  logic [7:0]  seg_states_q, seg_extra_q, seg_dozens_q, seg_units_q;
  logic [1:0]  dozens_q;
  logic [3:0]  units_q;
  logic        value_ok_q, frame_valid_q, stale_q, bus_error_q;
  logic [4:0]  units_dec, dozens_dec;
  logic        dozens_legal;

  seg_settle_filter #(
    .SETTLE_CYCLES   (SETTLE_CYCLES),
    .DIGIT_ACTIVE_LOW(DIGIT_ACTIVE_LOW),
    .SEG_ACTIVE_LOW  (SEG_ACTIVE_LOW)
  ) u_filter (
    .clk_i      (clock_50MHz),
    .rst_i      (reset),
    .digits_i   (disp_bus.digits),
    .segments_i (disp_bus.segments),
    .cap_stb_o  (cap_stb),
    .cap_idx_o  (cap_idx),
    .cap_seg_o  (cap_seg),
    .multi_stb_o(multi_stb)
  );

  assign units_dec    = seg_decode(shadow_q[DIG_UNITS][6:0]);
  assign dozens_dec   = seg_decode(shadow_q[DIG_DOZENS][6:0]);
  assign dozens_legal = dozens_dec[4] && (dozens_dec[3:2] == 2'b00);
  assign complete     = (seen_q == 4'b1111);

  // Seen-mask and timeout next state; a capture landing on completion
  // starts the next frame instead of being lost.
  always_comb begin
    cap_mask = cap_stb ? (4'b0001 << cap_idx) : 4'b0000;
    seen_d   = complete ? cap_mask : (seen_q | cap_mask);
    if (complete)         tmo_d = '0;
    else if (tmo_q < TMO) tmo_d = tmo_q + 21'd1;
    else                  tmo_d = TMO;
  end

  // Shadows, frame publication, timeout and error pulse.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      seen_q        <= '0;
      tmo_q         <= '0;
      seg_states_q  <= '0;
      seg_extra_q   <= '0;
      seg_dozens_q  <= '0;
      seg_units_q   <= '0;
      dozens_q      <= '0;
      units_q       <= '0;
      value_ok_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      seen_q        <= seen_d;
      tmo_q         <= tmo_d;
      stale_q       <= (tmo_d == TMO);
      bus_error_q   <= multi_stb;
      frame_valid_q <= complete;
      if (cap_stb) shadow_q[cap_idx] <= cap_seg;
      if (complete) begin
        seg_states_q <= shadow_q[DIG_STATES];
        seg_extra_q  <= shadow_q[DIG_EXTRA];
        seg_dozens_q <= shadow_q[DIG_DOZENS];
        seg_units_q  <= shadow_q[DIG_UNITS];
        dozens_q     <= dozens_legal ? dozens_dec[1:0] : 2'd0;
        units_q      <= units_dec[3:0];
        value_ok_q   <= units_dec[4] && dozens_legal;
      end
    end
  end

  assign seg_states  = seg_states_q;
  assign seg_extra   = seg_extra_q;
  assign seg_dozens  = seg_dozens_q;
  assign seg_units   = seg_units_q;
  assign dozens      = dozens_q;
  assign units       = units_q;
  assign value_ok    = value_ok_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;
  assign bus_error   = bus_error_q;

endmodule
